// File: rtl/sigma_delta_audio_ctrl.sv
// sigma_delta_audio_ctrl
//
// Front-end controller for a first-order sigma-delta audio DAC. It queues
// offset-binary samples from a producer, derives the modulator clock enable
// and the sample-update strobe from two programmable dividers, and ramps a
// 0..16 gain on enable/mute so the output never steps abruptly. Each sample
// strobe pops one word, scales it around midscale and registers it onto
// DAC_DATA.
//
// Ports
//   CLK         system clock, rising edge
//   RESET_N     asynchronous active-low reset
//   ENABLE      audio path enable
//   MUTE        soft mute request
//   DIV         modulator tick period = DIV+1 CLK cycles
//   OSR         sample period = OSR+1 modulator ticks
//   S_DATA      producer sample, offset binary (excess 2**MSBI)
//   S_VALID     producer offers S_DATA
//   S_READY     sample accepted when S_VALID && S_READY
//   DAC_DATA    scaled word to the DAC input
//   DAC_CEN     one-cycle modulator enable
//   UNDERRUN    one-cycle pulse: sample strobe found the FIFO empty
//   FIFO_LEVEL  entries held, 0..2**DEPTH_LOG2

module sigma_delta_audio_ctrl #(
  parameter int MSBI       = 7,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                ENABLE,
  input  logic                MUTE,
  input  logic [7:0]          DIV,
  input  logic [7:0]          OSR,
  input  logic [MSBI:0]       S_DATA,
  input  logic                S_VALID,
  output logic                S_READY,
  output logic [MSBI:0]       DAC_DATA,
  output logic                DAC_CEN,
  output logic                UNDERRUN,
  output logic [DEPTH_LOG2:0] FIFO_LEVEL
);

  localparam int DATA_W = MSBI + 1;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int LVL_W  = DEPTH_LOG2 + 1;

  localparam logic [MSBI:0]       MID      = {1'b1, {MSBI{1'b0}}};
  localparam logic [LVL_W-1:0]    LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [LVL_W-1:0]    LVL_ONE  = LVL_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [4:0]          GAIN_MAX = 5'd16;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_RAMP_UP   = 2'd1;
  localparam logic [1:0] S_RUN       = 2'd2;
  localparam logic [1:0] S_RAMP_DOWN = 2'd3;

  // MID + floor((s - MID) * g / 16). With g <= 16 the result always lands
  // back inside the word range, so no clamp is required.
  function automatic logic [MSBI:0] scale_sample(input logic [MSBI:0] s,
                                                 input logic [4:0]    g);
    logic signed [MSBI+1:0] d;
    logic signed [MSBI+7:0] d_x;
    logic signed [MSBI+7:0] g_x;
    logic signed [MSBI+7:0] prod;
    logic signed [MSBI+7:0] shifted;
    d       = $signed({1'b0, s}) - $signed({1'b0, MID});
    d_x     = {{6{d[MSBI+1]}}, d};
    g_x     = $signed({{(MSBI+3){1'b0}}, g});
    prod    = d_x * g_x;
    shifted = prod >>> 4;
    return shifted[MSBI:0] + MID;
  endfunction

  logic [7:0]            div_cnt_q, div_cnt_d;
  logic [7:0]            tick_cnt_q, tick_cnt_d;
  logic                  cen_q;
  logic                  tick;
  logic                  strobe;

  logic [1:0]            state_q, state_d;
  logic [4:0]            gain_q, gain_d;
  logic [MSBI:0]         last_q, last_d;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  s_ready;
  logic                  push;
  logic                  pop;
  logic                  flush;

  logic [MSBI:0]         dac_word_p0, dac_word_p1;
  logic                  underrun_p0, underrun_p1;

  // ---- stage p0: dividers, FSM, FIFO pop and scaling -----------------------

  always_comb begin
    tick       = (div_cnt_q >= DIV);
    div_cnt_d  = tick ? 8'd0 : div_cnt_q + 8'd1;
    tick_cnt_d = tick_cnt_q;
    strobe     = 1'b0;
    if (tick) begin
      if (tick_cnt_q >= OSR) begin
        tick_cnt_d = 8'd0;
        strobe     = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + 8'd1;
      end
    end
  end

  assign fifo_full  = (level_q == LVL_FULL);
  assign fifo_empty = (level_q == '0);
  assign s_ready    = !fifo_full && (state_q != S_IDLE);
  assign push       = S_VALID && s_ready;

  always_comb begin
    state_d     = state_q;
    gain_d      = gain_q;
    last_d      = last_q;
    dac_word_p0 = dac_word_p1;
    underrun_p0 = 1'b0;
    pop         = 1'b0;

    // Mode changes follow ENABLE/MUTE on any cycle; the gain only moves on
    // a sample strobe, so the audible ramp stays locked to the sample rate.
    case (state_q)
      S_IDLE: begin
        if (ENABLE && !MUTE) state_d = S_RAMP_UP;
      end
      S_RAMP_UP, S_RUN: begin
        if (!ENABLE || MUTE) state_d = S_RAMP_DOWN;
      end
      S_RAMP_DOWN: begin
        if (ENABLE && !MUTE) begin
          state_d = S_RAMP_UP;
        end else if (gain_q == 5'd0 && !ENABLE) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (strobe && state_q != S_IDLE && state_d != S_IDLE) begin
      case (state_d)
        S_RAMP_UP: begin
          gain_d = (gain_q >= GAIN_MAX) ? GAIN_MAX : gain_q + 5'd1;
          if (gain_d == GAIN_MAX) state_d = S_RUN;
        end
        S_RUN: begin
          gain_d = GAIN_MAX;
        end
        S_RAMP_DOWN: begin
          if (gain_q != 5'd0) gain_d = gain_q - 5'd1;
        end
        default: ;
      endcase

      // An empty FIFO repeats the previous sample rather than jumping to
      // midscale; a word pushed on this same edge is not forwarded.
      if (fifo_empty) begin
        underrun_p0 = 1'b1;
      end else begin
        pop    = 1'b1;
        last_d = mem_q[rd_ptr_q];
      end
      dac_word_p0 = scale_sample(last_d, gain_d);
    end

    if (state_d == S_IDLE) begin
      gain_d      = 5'd0;
      last_d      = MID;
      dac_word_p0 = MID;
    end
  end

  assign flush = (state_d == S_IDLE);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop) begin
        level_d = level_q + LVL_ONE;
      end else if (pop && !push) begin
        level_d = level_q - LVL_ONE;
      end
    end
  end

  // ---- stage p1: registered state and DAC-facing outputs -------------------

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div_cnt_q   <= 8'd0;
      tick_cnt_q  <= 8'd0;
      cen_q       <= 1'b0;
      state_q     <= S_IDLE;
      gain_q      <= 5'd0;
      last_q      <= MID;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      dac_word_p1 <= MID;
      underrun_p1 <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      cen_q       <= tick;
      state_q     <= state_d;
      gain_q      <= gain_d;
      last_q      <= last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      dac_word_p1 <= dac_word_p0;
      underrun_p1 <= underrun_p0;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= S_DATA;
  end

  assign S_READY    = s_ready;
  assign DAC_DATA   = dac_word_p1;
  assign DAC_CEN    = cen_q;
  assign UNDERRUN   = underrun_p1;
  assign FIFO_LEVEL = level_q;

endmodule
